i2c_arbiter: RTL and testbench

//  Shares one i2c_master between NREQ requesters (e.g. sensor poller, config loader).

---
 rtl/i2c_arbiter_pkg.sv | 25 ++
 rtl/i2c_arbiter_rr_arb.sv | 32 +++
 rtl/i2c_arbiter.sv | 135 +++++++++++++
 tb/tb_i2c_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arbiter_pkg.sv
// Shared widths, FSM encodings and the latched command record for the i2c arbiter.
// Pure declarations: no logic, no latency, no flow control of its own.
package i2c_arbiter_pkg;

  localparam int ADDR_W = 7;
  localparam int MEM_W  = 5;
  localparam int DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [MEM_W-1:0]  mem;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/i2c_arbiter_rr_arb.sv
// Round-robin one-hot pick: first asserted req at or above ptr, wrapping.
// Combinational (0 cycles); no backpressure, the caller decides when to sample.
module i2c_arbiter_rr_arb #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master among NREQ requesters, round-robin, one register transaction per grant.
// m_en 1 cycle after req seen in IDLE, done 1 cycle after m_busy falls; requesters hold req until done.
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int TOUT   = 255,
  parameter int TOUT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [MEM_W*NREQ-1:0]    req_mem,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     tout,
  output logic                     m_en,
  output logic [ADDR_W-1:0]        m_addr,
  output logic                     m_rw,
  output logic [MEM_W-1:0]         m_mem_addr,
  output logic [DATA_W-1:0]        m_data_wr,
  input  logic [DATA_W-1:0]        m_data_rd,
  input  logic                     m_ack_err,
  input  logic                     m_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [2:0]        state;
  logic [PTR_W-1:0]  rr;
  logic [PTR_W-1:0]  win;
  logic [TOUT_W-1:0] cnt;
  logic [NREQ-1:0]   pick;
  logic [PTR_W-1:0]  pick_idx;
  cmd_t              pick_cmd;
  cmd_t              cmd_q;

  i2c_arbiter_rr_arb #(
    .NREQ (NREQ),
    .PTR_W(PTR_W)
  ) u_rr_arb (
    .req(req),
    .ptr(rr),
    .gnt(pick),
    .idx(pick_idx)
  );

  // One-hot mux of the winner's packed command fields.
  always_comb begin
    pick_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_cmd.rw    = req_rw[i];
        pick_cmd.mem   = req_mem[i*MEM_W +: MEM_W];
        pick_cmd.wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign m_addr     = cmd_q.addr;
  assign m_rw       = cmd_q.rw;
  assign m_mem_addr = cmd_q.mem;
  assign m_data_wr  = cmd_q.wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      rr    <= '0;
      win   <= '0;
      cnt   <= '0;
      cmd_q <= '0;
      gnt   <= '0;
      done  <= '0;
      rdata <= '0;
      err   <= 1'b0;
      tout  <= 1'b0;
      m_en  <= 1'b0;
    end else begin
      m_en <= 1'b0;
      done <= '0;
      case (state)
        ST_IDLE: begin
          // A still-busy master is finishing or recovering; do not launch over it.
          if (|req && !m_busy) begin
            win   <= pick_idx;
            gnt   <= pick;
            cmd_q <= pick_cmd;
            m_en  <= 1'b1;
            state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (m_busy) begin
            state <= ST_WAIT_DONE;
          end else if (cnt == TOUT_W'(TOUT)) begin
            done  <= gnt;
            err   <= 1'b1;
            tout  <= 1'b1;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!m_busy) begin
            done <= gnt;
            err  <= m_ack_err;
            tout <= 1'b0;
            if (cmd_q.rw == RW_READ && !m_ack_err) rdata <= m_data_rd;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          gnt   <= '0;
          err   <= 1'b0;
          tout  <= 1'b0;
          rr    <= (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: stubbed i2c_master with two slaves (addr 1 and 2), directed vectors,
// corner sequences and random traffic checked every cycle against a transaction-level model.
module tb_i2c_arbiter;

  localparam int NREQ   = 3;
  localparam int TOUT   = 12;
  localparam int TOUT_W = 4;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [7*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]     req_rw;
  logic [5*NREQ-1:0]   req_mem;
  logic [8*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [7:0]          rdata;
  logic                err;
  logic                tout;
  logic                m_en;
  logic [6:0]          m_addr;
  logic                m_rw;
  logic [4:0]          m_mem_addr;
  logic [7:0]          m_data_wr;
  logic [7:0]          m_data_rd;
  logic                m_ack_err;
  logic                m_busy;
  logic                stub_dead;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  i2c_arbiter #(.NREQ(NREQ), .TOUT(TOUT), .TOUT_W(TOUT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_mem(req_mem), .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
    .err(err), .tout(tout), .m_en(m_en), .m_addr(m_addr), .m_rw(m_rw),
    .m_mem_addr(m_mem_addr), .m_data_wr(m_data_wr), .m_data_rd(m_data_rd),
    .m_ack_err(m_ack_err), .m_busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) oh_idx = i;
  endfunction

  // ---------------- master stub: slaves at 1 and 2, 32 registers each ----------------
  logic [7:0] sl_mem [0:1][0:31];
  initial begin : stub
    int ph, dly, len;
    logic [6:0] s_addr; logic s_rw; logic [4:0] s_mem; logic [7:0] s_wd;
    ph = 0; dly = 0; len = 0; s_addr = '0; s_rw = 1'b0; s_mem = '0; s_wd = '0;
    m_busy = 1'b0; m_ack_err = 1'b0; m_data_rd = 8'h00;
    for (int a = 0; a < 2; a++) for (int r = 0; r < 32; r++) sl_mem[a][r] = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        m_busy = 1'b0; ph = 0;
      end else begin
        case (ph)
          0: if (m_en && !stub_dead) begin
               s_addr = m_addr; s_rw = m_rw; s_mem = m_mem_addr; s_wd = m_data_wr;
               dly = $urandom_range(0, 3); len = $urandom_range(1, 4); ph = 1;
             end
          1: if (dly == 0) begin m_busy = 1'b1; ph = 2; end else dly--;
          default: if (len == 0) begin
               if (s_addr == 7'd1 || s_addr == 7'd2) begin
                 m_ack_err = 1'b0;
                 if (s_rw) begin
                   sl_mem[int'(s_addr) - 1][s_mem] = s_wd;
                   m_data_rd = 8'($urandom);
                 end else m_data_rd = sl_mem[int'(s_addr) - 1][s_mem];
               end else begin
                 m_ack_err = 1'b1; m_data_rd = 8'($urandom);
               end
               m_busy = 1'b0; ph = 0;
             end else len--;
        endcase
      end
    end
  end

  // ---------------- transaction-level reference model / monitor ----------------
  logic [7:0] mdl_mem [0:1][0:31];
  initial begin : monitor
    logic [NREQ-1:0] p_req; logic [7*NREQ-1:0] p_addr; logic [NREQ-1:0] p_rw;
    logic [5*NREQ-1:0] p_mem; logic [8*NREQ-1:0] p_wd;
    logic p_busy, p_idle, outst, o_start, exp_en, exp_done, dead_t, fell, e_err, e_tout;
    logic [6:0] t_addr; logic t_rw; logic [4:0] t_mem; logic [7:0] t_wd; logic [7:0] exp_rdata;
    int win, rr_m; int unsigned en_cyc, fall_cyc;
    p_req = '0; p_addr = '0; p_rw = '0; p_mem = '0; p_wd = '0; p_busy = 1'b0; p_idle = 1'b0;
    outst = 1'b0; dead_t = 1'b0; fell = 1'b0; win = 0; rr_m = 0; en_cyc = 0; fall_cyc = 0;
    t_addr = '0; t_rw = 1'b0; t_mem = '0; t_wd = '0; exp_rdata = 8'h00;
    for (int a = 0; a < 2; a++) for (int r = 0; r < 32; r++) mdl_mem[a][r] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_outputs", {gnt, done, rdata, err, tout, m_en, m_addr, m_rw, m_mem_addr, m_data_wr}, 64'd0);
        outst = 1'b0; rr_m = 0; exp_rdata = 8'h00; p_idle = 1'b0;
      end else begin
        o_start = outst;
        exp_en  = p_idle && (p_req != '0) && !p_busy;
        check("m_en", m_en, exp_en);
        if (exp_en) begin
          win = -1;
          for (int k = 0; k < NREQ; k++)
            if (win < 0 && p_req[(rr_m + k) % NREQ]) win = (rr_m + k) % NREQ;
          outst = 1'b1; en_cyc = cyc; fell = 1'b0; dead_t = stub_dead;
          t_addr = p_addr[7*win +: 7]; t_rw = p_rw[win];
          t_mem  = p_mem[5*win +: 5];  t_wd = p_wd[8*win +: 8];
        end
        if (outst) begin
          check("m_cmd_stable", {m_addr, m_rw, m_mem_addr, m_data_wr}, {t_addr, t_rw, t_mem, t_wd});
          if (p_busy && !m_busy) begin fell = 1'b1; fall_cyc = cyc; end
          exp_done = dead_t ? (cyc == en_cyc + TOUT + 2) : (fell && cyc == fall_cyc + 1);
          check("gnt", gnt, 64'd1 << win);
          check("done", done, exp_done ? (64'd1 << win) : 64'd0);
          if (exp_done) begin
            if (dead_t) begin
              e_err = 1'b1; e_tout = 1'b1;
            end else if (t_addr == 7'd1 || t_addr == 7'd2) begin
              e_err = 1'b0; e_tout = 1'b0;
              if (t_rw) mdl_mem[int'(t_addr) - 1][t_mem] = t_wd;
              else exp_rdata = mdl_mem[int'(t_addr) - 1][t_mem];
            end else begin
              e_err = 1'b1; e_tout = 1'b0;
            end
            check("err", err, e_err);
            check("tout", tout, e_tout);
            rr_m  = (win + 1) % NREQ;
            outst = 1'b0;
          end
        end else begin
          check("gnt_idle", gnt, 64'd0);
          check("done_idle", done, 64'd0);
        end
        check("rdata", rdata, exp_rdata);
        p_idle = !o_start && !exp_en;
      end
      p_req = req; p_addr = req_addr; p_rw = req_rw; p_mem = req_mem; p_wd = req_wdata;
      p_busy = m_busy;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int         rq;
    logic [6:0] addr;
    logic       rw;
    logic [4:0] mem;
    logic [7:0] wd;
    logic       dead;
    logic       exp_err;
    logic       exp_tout;
    logic [7:0] exp_rd;
  } vec_t;

  task automatic set_cmd(input int i, input logic [6:0] a, input logic rw, input logic [4:0] m,
                         input logic [7:0] d);
    req_addr[7*i +: 7] = a; req_rw[i] = rw; req_mem[5*i +: 5] = m; req_wdata[8*i +: 8] = d;
  endtask

  task automatic wait_done(output int idx, output int unsigned at);
    logic seen;
    seen = 1'b0; idx = -1; at = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done != '0) begin seen = 1'b1; idx = oh_idx(done); at = cyc; end
    end
    if (!seen) check("done_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
  endtask

  initial begin : main
    vec_t tbl[10];
    int idx; int unsigned at, c0; logic got;
    rst = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_mem = '0; req_wdata = '0; stub_dead = 1'b0;
    //           rq addr  rw    mem    wd     dead  err   tout  rdata
    tbl[0] = '{0, 7'd1, 1'b1, 5'd3, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{0, 7'd1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33};
    tbl[2] = '{1, 7'd2, 1'b1, 5'd1, 8'hBB, 1'b0, 1'b0, 1'b0, 8'h33};
    tbl[3] = '{1, 7'd3, 1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[4] = '{2, 7'd2, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hBB};
    tbl[5] = '{0, 7'd2, 1'b1, 5'd5, 8'h5A, 1'b1, 1'b1, 1'b1, 8'hBB};
    tbl[6] = '{1, 7'd2, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{2, 7'd1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33};
    tbl[8] = '{0, 7'd3, 1'b1, 5'd2, 8'h77, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[9] = '{1, 7'd1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33};
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      set_cmd(tbl[v].rq, tbl[v].addr, tbl[v].rw, tbl[v].mem, tbl[v].wd);
      stub_dead = tbl[v].dead; req[tbl[v].rq] = 1'b1; c0 = cyc;
      wait_done(idx, at);
      check("vec_done_idx", 64'(idx), 64'(tbl[v].rq));
      check("vec_err", err, tbl[v].exp_err);
      check("vec_tout", tout, tbl[v].exp_tout);
      check("vec_rdata", rdata, tbl[v].exp_rd);
      if (tbl[v].dead) check("vec_tout_latency", at - c0, TOUT + 3);
      @(posedge clk); #1; req = '0; stub_dead = 1'b0;
    end

    // Simultaneous requests straight after reset: 0 then 1.
    pulse_reset();
    @(posedge clk); #1;
    set_cmd(0, 7'd1, 1'b1, 5'd4, 8'h44); set_cmd(1, 7'd2, 1'b1, 5'd1, 8'hBB);
    req = 3'b011;
    wait_done(idx, at);
    check("t2_first", 64'(idx), 64'd0);
    check("t2_first_gnt", gnt, 64'd1);
    @(posedge clk); #1; req[0] = 1'b0;
    wait_done(idx, at);
    check("t2_second", 64'(idx), 64'd1);
    check("t2_second_gnt", gnt, 64'd2);
    @(posedge clk); #1; req = '0;

    // Both held continuously: grants alternate 0,1,0,1.
    @(posedge clk); #1;
    set_cmd(0, 7'd2, 1'b0, 5'd1, 8'h00); set_cmd(1, 7'd1, 1'b0, 5'd4, 8'h00);
    req = 3'b011;
    for (int k = 0; k < 4; k++) begin
      wait_done(idx, at);
      check("t3_order", 64'(idx), 64'(k % 2));
      check("t3_rdata", rdata, (k % 2 == 0) ? 64'hBB : 64'h44);
    end
    @(posedge clk); #1; req = '0;

    // Reset during WAIT_DONE: outputs clear, no done, request served afterwards.
    @(posedge clk); #1;
    set_cmd(0, 7'd1, 1'b0, 5'd3, 8'h00); req[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (m_busy) got = 1'b1;
    end
    check("t6_busy_seen", got, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("t6_outputs_zero", {gnt, done, rdata, err, tout, m_en, m_addr, m_rw, m_mem_addr, m_data_wr}, 64'd0);
    @(posedge clk); @(posedge clk); #1; rst = 1'b1;
    wait_done(idx, at);
    check("t6_after_idx", 64'(idx), 64'd0);
    check("t6_after_err", err, 1'b0);
    check("t6_after_rdata", rdata, 64'h33);
    @(posedge clk); #1; req = '0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      stub_dead = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (done[i] || $urandom_range(0, 63) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_cmd(i, 7'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 8'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    req = '0; stub_dead = 1'b0;
    repeat (40) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
